control_sequencer: RTL and testbench
====================================

# control_sequencer

Multi-cycle fetch/decode/execute controller for the 16-bit RISC datapath. Drives instruction-register load (`IL`), program-counter increment/load, memory read/write strobes, register-file write enable and ALU function select from the 4-bit `opcode` field. Waits on a memory ready handshake with a bounded timeout. Sits between the instruction register, register file, ALU, PC and memory interface.

## Interface
- `WAIT_LIMIT`, default 15: max consecutive FETCH/MEM cycles without `mem_ready` before FAULT; range 1–255.
- `clk` input 1: system clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-high; forces FETCH, clears counter and sticky flags.
- `opcode` input 4: instruction register opcode field; sampled only in DECODE.
- `zero` input 1: ALU zero flag; sampled only in EXEC for BRZ.
- `mem_ready` input 1: memory completes current read/write this cycle.
- `IL` output 1: instruction load strobe to instruction register.
- `pc_inc` output 1: increment PC.
- `pc_load` output 1: load PC from ALU result.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `addr_sel` output 1: 0 = PC drives address, 1 = register A drives address.
- `RW` output 1: register-file write of `DA`.
- `MD` output 1: write-data select; 0 = ALU, 1 = memory.
- `FS` output 4: ALU function select.
- `state` output 3: current state encoding.
- `halted` output 1: high in HALT.
- `fault` output 1: high in FAULT.
- `trap` output 1: high in TRAP; constant 0 when trap is compiled out.

## Operation
- Opcodes: 0000 NOP; 0001 ADD; 0010 SUB; 0011 AND; 0100 OR; 0101 XOR; 0110 NOT; 0111 SHL; 1000 SHR; 1001 LD; 1010 ST; 1011 BRZ; 1100 JMP; 1101–1110 reserved; 1111 HALT.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4, FAULT=5, TRAP=6.
- FETCH:
  - Outputs: `mem_read`=1, `addr_sel`=0.
  - If `mem_ready`: `IL`=1 and `pc_inc`=1 in the same cycle, next state DECODE.
  - Otherwise remain in FETCH.
- DECODE: all strobes 0. Next state by opcode:
  - NOP → FETCH.
  - ALU ops, BRZ, JMP → EXEC.
  - LD, ST → MEM.
  - HALT → HALT.
  - Reserved → see Configuration.
- EXEC, always returns to FETCH:
  - ALU ops: `FS`=opcode, `RW`=1, `MD`=0.
  - BRZ: `FS`=0000 (pass A), `pc_load`=`zero`.
  - JMP: `FS`=0000, `pc_load`=1.
- MEM:
  - Outputs: `addr_sel`=1. LD asserts `mem_read`; ST asserts `mem_write`.
  - On `mem_ready`: LD also asserts `RW`=1, `MD`=1. Next state FETCH.
- Wait counter (8 bit):
  - Cleared on entry to FETCH or MEM; increments each FETCH/MEM cycle without `mem_ready`.
  - At `WAIT_LIMIT` with `mem_ready`=0, next state FAULT.
  - If `mem_ready` arrives in the limit cycle, ready wins and there is no fault.
- HALT, FAULT, TRAP: terminal; all strobes 0; exit only via `reset`.
- Outputs not listed for a state are 0. `FS` is 0000 outside EXEC.

## Timing
- Strobes are combinational from the state register, the latched opcode (captured at DECODE), `mem_ready` and `zero`.
- `IL` rises during the FETCH ready cycle. The instruction register captures on the falling edge inside that cycle, so `opcode` is stable at the DECODE rising edge.
- Latency with zero wait states:
  - NOP: 2 cycles.
  - ALU, BRZ, JMP: 3 cycles.
  - LD, ST: 3 cycles.
  - Each wait cycle adds 1.
- While `reset` is high, all outputs are 0 and `state`=0. The first rising edge after release is the first FETCH cycle.
- A `reset` mid-instruction abandons it immediately: no `RW`, `pc_load` or `mem_write` completes afterward.
- `opcode` and `zero` changes outside DECODE/EXEC have no effect.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: reserved opcodes 1101/1110 go DECODE → TRAP, `trap`=1 until reset.
- `CTRL_ILLEGAL_TRAP_EN` undefined: reserved opcodes behave as NOP (DECODE → FETCH), TRAP is unreachable, `trap` is tied 0.

## Test plan
- ALU path: reset, `mem_ready`=1 always, opcode 0001 → states 0,1,2,0; `IL`/`pc_inc` in cycle 1, `RW`=1 and `FS`=0001 in cycle 3, `MD`=0.
- Load with waits: opcode 1001, `mem_ready` low 3 MEM cycles then high → `mem_read`=1 and `addr_sel`=1 for 4 cycles, `RW`=1 and `MD`=1 only in the 4th, then FETCH.
- Branch: BRZ with `zero`=0 → `pc_load`=0; repeat with `zero`=1 → `pc_load`=1 in EXEC; JMP → `pc_load`=1.
- Timeout: `WAIT_LIMIT`=4, `mem_ready` held 0 in FETCH → FAULT after 5th FETCH cycle, `fault`=1 sticky; ready in the limit cycle → DECODE, no fault.
- Terminal/reset: opcode 1111 → `halted`=1 and no strobes for 20 cycles; assert `reset` mid-MEM (ST) → `mem_write` drops immediately, `state`=0.
- Reserved opcode 1101: with macro → `trap`=1, `state`=6; without macro → returns to FETCH, `trap`=0.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit RISC datapath.
// Ports: clk, reset (async high), opcode/zero/mem_ready in; IL, pc_inc,
// pc_load, mem_read, mem_write, addr_sel, RW, MD, FS, state, halted, fault,
// trap out. WAIT_LIMIT bounds memory stalls. Define CTRL_ILLEGAL_TRAP_EN to
// send reserved opcodes to TRAP instead of treating them as NOP.
module control_sequencer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IL,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       RW,
  output logic       MD,
  output logic [3:0] FS,
  output logic [2:0] state,
  output logic       halted,
  output logic       fault,
  output logic       trap
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALT   = 3'd4,
    FAULT  = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t     cur;
  state_t     nxt;
  logic [3:0] op_q;
  logic [7:0] cnt;
  logic       waiting;
  logic       expired;

  logic d_alu;
  logic d_ctl;
  logic d_mem;
  logic d_halt;

  assign d_alu  = opcode >= 4'h1 && opcode <= 4'h8;
  assign d_ctl  = opcode == 4'hB || opcode == 4'hC;
  assign d_mem  = opcode == 4'h9 || opcode == 4'hA;
  assign d_halt = opcode == 4'hF;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic d_rsv;
  assign d_rsv = opcode == 4'hD || opcode == 4'hE;
`endif

  // Counter is zero whenever FETCH/MEM is entered because
  // leaving either state requires a non-stall cycle.
  assign waiting = (cur == FETCH || cur == MEM) && !mem_ready;
  assign expired = waiting && (cnt == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur  <= FETCH;
      op_q <= 4'h0;
      cnt  <= 8'd0;
    end else begin
      cur <= nxt;
      if (cur == DECODE)
        op_q <= opcode;
      cnt <= waiting ? cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    nxt       = cur;
    IL        = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    RW        = 1'b0;
    MD        = 1'b0;
    FS        = 4'h0;
    state     = cur;
    halted    = cur == HALT;
    fault     = cur == FAULT;
`ifdef CTRL_ILLEGAL_TRAP_EN
    trap      = cur == TRAP;
`else
    trap      = 1'b0;
`endif
    unique case (cur)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          IL     = 1'b1;
          pc_inc = 1'b1;
          nxt    = DECODE;
        end else if (expired) begin
          nxt = FAULT;
        end
      end
      DECODE: begin
        unique case (1'b1)
          d_alu, d_ctl: nxt = EXEC;
          d_mem:        nxt = MEM;
          d_halt:       nxt = HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          d_rsv:        nxt = TRAP;
`endif
          default:      nxt = FETCH;
        endcase
      end
      EXEC: begin
        nxt = FETCH;
        unique case (op_q)
          4'hB: pc_load = zero;
          4'hC: pc_load = 1'b1;
          default: begin
            FS = op_q;
            RW = 1'b1;
          end
        endcase
      end
      MEM: begin
        addr_sel = 1'b1;
        if (op_q == 4'h9) begin
          mem_read = 1'b1;
          RW       = mem_ready;
          MD       = mem_ready;
        end else begin
          mem_write = 1'b1;
        end
        if (mem_ready)
          nxt = FETCH;
        else if (expired)
          nxt = FAULT;
      end
      default: ;
    endcase
    // Async reset must silence the FETCH read strobe at once.
    if (reset) begin
      IL        = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr_sel  = 1'b0;
      RW        = 1'b0;
      MD        = 1'b0;
      FS        = 4'h0;
      state     = 3'd0;
      halted    = 1'b0;
      fault     = 1'b0;
      trap      = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: an instruction-level trace
// model predicts every cycle's outputs for two DUTs (WAIT_LIMIT 15 and 4).
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       il1, pi1, pl1, mr1, mw1, as1, rw1, md1, h1, f1, t1;
  logic [3:0] fs1;
  logic [2:0] st1;
  logic       il2, pi2, pl2, mr2, mw2, as2, rw2, md2, h2, f2, t2;
  logic [3:0] fs2;
  logic [2:0] st2;

  logic [17:0] obs1, obs2;

  int total;
  int passed;

  localparam logic [7:0] S_IL = 8'h80;
  localparam logic [7:0] S_PI = 8'h40;
  localparam logic [7:0] S_PL = 8'h20;
  localparam logic [7:0] S_MR = 8'h10;
  localparam logic [7:0] S_MW = 8'h08;
  localparam logic [7:0] S_AS = 8'h04;
  localparam logic [7:0] S_RW = 8'h02;
  localparam logic [7:0] S_MD = 8'h01;

  typedef struct {
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [17:0] exp;
  } cyc_t;

  cyc_t tq[$];

  control_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .IL(il1), .pc_inc(pi1), .pc_load(pl1),
    .mem_read(mr1), .mem_write(mw1), .addr_sel(as1), .RW(rw1),
    .MD(md1), .FS(fs1), .state(st1), .halted(h1), .fault(f1),
    .trap(t1)
  );

  control_sequencer #(.WAIT_LIMIT(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .IL(il2), .pc_inc(pi2), .pc_load(pl2),
    .mem_read(mr2), .mem_write(mw2), .addr_sel(as2), .RW(rw2),
    .MD(md2), .FS(fs2), .state(st2), .halted(h2), .fault(f2),
    .trap(t2)
  );

  assign obs1 = {il1, pi1, pl1, mr1, mw1, as1, rw1, md1,
                 fs1, st1, h1, f1, t1};
  assign obs2 = {il2, pi2, pl2, mr2, mw2, as2, rw2, md2,
                 fs2, st2, h2, f2, t2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] r4();
    return 4'($urandom);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  // {strobes, FS, state, halted/fault/trap}
  function automatic logic [17:0] ev(input logic [7:0] s,
                                     input logic [3:0] fs,
                                     input logic [2:0] st,
                                     input logic [2:0] hft);
    return {s, fs, st, hft};
  endfunction

  task automatic push(input logic [3:0] op, input logic z,
                      input logic rdy, input logic [17:0] e);
    cyc_t c;
    c.op  = op;
    c.z   = z;
    c.rdy = rdy;
    c.exp = e;
    tq.push_back(c);
  endtask

  // Reference: cycle trace of one instruction from FETCH onward.
  // Inputs irrelevant to a cycle are randomised.
  task automatic gen(input logic [3:0] op, input int fw,
                     input int mw, input logic z);
    logic [7:0] s;
    for (int i = 0; i < fw; i++)
      push(r4(), r1(), 1'b0, ev(S_MR, 4'h0, 3'd0, 3'd0));
    push(r4(), r1(), 1'b1, ev(S_IL | S_PI | S_MR, 4'h0, 3'd0, 3'd0));
    push(op, r1(), r1(), ev(8'h0, 4'h0, 3'd1, 3'd0));
    if (op >= 4'h1 && op <= 4'h8) begin
      push(r4(), r1(), r1(), ev(S_RW, op, 3'd2, 3'd0));
    end else if (op == 4'hB) begin
      push(r4(), z, r1(), ev(z ? S_PL : 8'h0, 4'h0, 3'd2, 3'd0));
    end else if (op == 4'hC) begin
      push(r4(), r1(), r1(), ev(S_PL, 4'h0, 3'd2, 3'd0));
    end else if (op == 4'h9 || op == 4'hA) begin
      s = (op == 4'h9) ? S_MR : S_MW;
      for (int i = 0; i < mw; i++)
        push(r4(), r1(), 1'b0, ev(s | S_AS, 4'h0, 3'd3, 3'd0));
      if (op == 4'h9)
        s = s | S_RW | S_MD;
      push(r4(), r1(), 1'b1, ev(s | S_AS, 4'h0, 3'd3, 3'd0));
    end
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode    = r4();
      zero      = r1();
      mem_ready = r1();
      #2;
      total++;
      if (obs1 !== 18'h0)
        $display("FAIL reset_d15: got %h want %h", obs1, 18'h0);
      else
        passed++;
      total++;
      if (obs2 !== 18'h0)
        $display("FAIL reset_d4: got %h want %h", obs2, 18'h0);
      else
        passed++;
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  task automatic test_paths;
    cyc_t c;
    do_reset;
    gen(4'h1, 0, 0, 1'b0);
    gen(4'h9, 0, 3, 1'b0);
    gen(4'hB, 0, 0, 1'b0);
    gen(4'hB, 0, 0, 1'b1);
    gen(4'hC, 0, 0, 1'b0);
    gen(4'hA, 2, 1, 1'b0);
    gen(4'h0, 1, 0, 1'b0);
    while (tq.size() > 0) begin
      c = tq.pop_front();
      opcode = c.op; zero = c.z; mem_ready = c.rdy;
      #2;
      total++;
      if (obs1 !== c.exp)
        $display("FAIL path: got %h want %h", obs1, c.exp);
      else
        passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    cyc_t c;
    do_reset;
    for (int k = 0; k < 40; k++)
      gen(4'($urandom_range(0, 12)), $urandom_range(0, 4),
          $urandom_range(0, 4), r1());
    while (tq.size() > 0) begin
      c = tq.pop_front();
      opcode = c.op; zero = c.z; mem_ready = c.rdy;
      #2;
      total++;
      if (obs1 !== c.exp)
        $display("FAIL random: got %h want %h", obs1, c.exp);
      else
        passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_halt;
    cyc_t c;
    do_reset;
    gen(4'hF, 1, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      push(r4(), r1(), r1(), ev(8'h0, 4'h0, 3'd4, 3'b100));
    while (tq.size() > 0) begin
      c = tq.pop_front();
      opcode = c.op; zero = c.z; mem_ready = c.rdy;
      #2;
      total++;
      if (obs1 !== c.exp)
        $display("FAIL halt: got %h want %h", obs1, c.exp);
      else
        passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    cyc_t c;
    do_reset;
    push(r4(), r1(), 1'b1, ev(S_IL | S_PI | S_MR, 4'h0, 3'd0, 3'd0));
    push(4'hA, r1(), r1(), ev(8'h0, 4'h0, 3'd1, 3'd0));
    push(r4(), r1(), 1'b0, ev(S_MW | S_AS, 4'h0, 3'd3, 3'd0));
    while (tq.size() > 0) begin
      c = tq.pop_front();
      opcode = c.op; zero = c.z; mem_ready = c.rdy;
      #2;
      total++;
      if (obs1 !== c.exp)
        $display("FAIL mid_pre: got %h want %h", obs1, c.exp);
      else
        passed++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    total++;
    if (obs1 !== ev(S_MW | S_AS, 4'h0, 3'd3, 3'd0))
      $display("FAIL mid_mem: got %h want %h", obs1,
               ev(S_MW | S_AS, 4'h0, 3'd3, 3'd0));
    else
      passed++;
    reset = 1'b1;
    #1;
    total++;
    if (obs1 !== 18'h0)
      $display("FAIL mid_rst: got %h want %h", obs1, 18'h0);
    else
      passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    gen(4'hC, 0, 0, 1'b0);
    gen(4'h0, 0, 0, 1'b0);
    while (tq.size() > 0) begin
      c = tq.pop_front();
      opcode = c.op; zero = c.z; mem_ready = c.rdy;
      #2;
      total++;
      if (obs1 !== c.exp)
        $display("FAIL mid_post: got %h want %h", obs1, c.exp);
      else
        passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_reserved;
    cyc_t c;
    logic [3:0] rop;
    for (int k = 0; k < 2; k++) begin
      rop = (k == 0) ? 4'hD : 4'hE;
      do_reset;
      gen(rop, 1, 0, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++)
        push(r4(), r1(), r1(), ev(8'h0, 4'h0, 3'd6, 3'b001));
`else
      gen(4'h1, 0, 0, 1'b0);
`endif
      while (tq.size() > 0) begin
        c = tq.pop_front();
        opcode = c.op; zero = c.z; mem_ready = c.rdy;
        #2;
        total++;
        if (obs1 !== c.exp)
          $display("FAIL reserved: got %h want %h", obs1, c.exp);
        else
          passed++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_timeout;
    cyc_t c;
    do_reset;
    for (int i = 0; i < 5; i++)
      push(r4(), r1(), 1'b0, ev(S_MR, 4'h0, 3'd0, 3'd0));
    for (int i = 0; i < 3; i++)
      push(r4(), r1(), r1(), ev(8'h0, 4'h0, 3'd5, 3'b010));
    while (tq.size() > 0) begin
      c = tq.pop_front();
      opcode = c.op; zero = c.z; mem_ready = c.rdy;
      #2;
      total++;
      if (obs2 !== c.exp)
        $display("FAIL tmo_fetch: got %h want %h", obs2, c.exp);
      else
        passed++;
      @(negedge clk);
    end
    do_reset;
    gen(4'h0, 4, 0, 1'b0);
    gen(4'h9, 0, 4, 1'b0);
    push(r4(), r1(), 1'b1, ev(S_IL | S_PI | S_MR, 4'h0, 3'd0, 3'd0));
    push(4'hA, r1(), r1(), ev(8'h0, 4'h0, 3'd1, 3'd0));
    for (int i = 0; i < 5; i++)
      push(r4(), r1(), 1'b0, ev(S_MW | S_AS, 4'h0, 3'd3, 3'd0));
    for (int i = 0; i < 2; i++)
      push(r4(), r1(), r1(), ev(8'h0, 4'h0, 3'd5, 3'b010));
    while (tq.size() > 0) begin
      c = tq.pop_front();
      opcode = c.op; zero = c.z; mem_ready = c.rdy;
      #2;
      total++;
      if (obs2 !== c.exp)
        $display("FAIL tmo_mem: got %h want %h", obs2, c.exp);
      else
        passed++;
      @(negedge clk);
    end
    do_reset;
    repeat (16) @(negedge clk);
    #2;
    total++;
    if (obs1 !== ev(8'h0, 4'h0, 3'd5, 3'b010))
      $display("FAIL lim15_fault: got %h want %h", obs1,
               ev(8'h0, 4'h0, 3'd5, 3'b010));
    else
      passed++;
    do_reset;
    repeat (15) @(negedge clk);
    opcode    = 4'h0;
    mem_ready = 1'b1;
    #2;
    total++;
    if (obs1 !== ev(S_IL | S_PI | S_MR, 4'h0, 3'd0, 3'd0))
      $display("FAIL lim15_ready: got %h want %h", obs1,
               ev(S_IL | S_PI | S_MR, 4'h0, 3'd0, 3'd0));
    else
      passed++;
    @(negedge clk);
    #2;
    total++;
    if (obs1 !== ev(8'h0, 4'h0, 3'd1, 3'd0))
      $display("FAIL lim15_dec: got %h want %h", obs1,
               ev(8'h0, 4'h0, 3'd1, 3'd0));
    else
      passed++;
    @(negedge clk);
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    reset     = 1'b1;
    opcode    = 4'h0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_paths;
    test_random;
    test_halt;
    test_reset_mid;
    test_reserved;
    test_timeout;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
